ps2_frame_rx: RTL

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit odd-parity frames and buffers received bytes in a small FIFO.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       read_fin,
    output logic       ready,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic                   filt_clk;
    logic [FW-1:0]          flt_cnt;
    logic                   sample_evt;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shreg;
    logic          parity_bit, stop_bit;
    logic          frame_ok, push;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          rf_q, pop, full, push_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s != filt_clk) begin
            if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= ~filt_clk;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end else begin
            flt_cnt <= '0;
        end
    end

    assign sample_evt = filt_clk & ~clk_s & (flt_cnt == FW'(FILTER_LEN - 1));
    assign frame_ok   = (^{shreg, parity_bit}) & stop_bit;
    assign push       = (state == CHECK) & frame_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_evt && !dat_s) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (sample_evt) begin
                        to_cnt  <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            shreg <= {dat_s, shreg[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            parity_bit <= dat_s;
                        end else begin
                            stop_bit <= dat_s;
                            state    <= CHECK;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        to_cnt    <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    frame_err <= ~frame_ok;
                    state     <= IDLE;
                    bit_cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pop is evaluated first, so a simultaneous push into a full buffer still fits.
    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign pop     = read_fin & ~rf_q & (count != '0);
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rf_q <= read_fin;
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push & full & ~pop) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign ready = (count != '0);
    assign data  = mem[rd_ptr];

endmodule
